// File: rtl/id_ex_decode.sv
// ID/EX stage: decodes a MIPS instruction into ALU code, operands and controls; one-cycle registered latency.
// Backpressure: stall holds the whole register, flush (or in_valid=0) loads a bubble; reset wins over both.
module id_ex_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        valid,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] store_data,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_ADDU = 4'd1,  ALU_SUB  = 4'd2,
                         ALU_SUBU = 4'd3,  ALU_AND  = 4'd4,  ALU_NOR  = 4'd5,
                         ALU_OR   = 4'd6,  ALU_XOR  = 4'd7,  ALU_SLL  = 4'd8,
                         ALU_SLLV = 4'd9,  ALU_SRL  = 4'd10, ALU_SRLV = 4'd11,
                         ALU_SRA  = 4'd12, ALU_SRAV = 4'd13, ALU_SLT  = 4'd14;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [3:0]  alu_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_eq;
    logic        branch_ne;
  } ex_reg_t;

  ex_reg_t     dec;
  ex_reg_t     ex_q;
  logic        legal;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign sext   = {{16{instr[15]}}, instr[15:0]};
  assign zext   = {16'b0, instr[15:0]};
  assign shamt  = {27'b0, instr[10:6]};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    if (in_valid) begin
      dec.valid = 1'b1;
      case (opcode)
        6'h00: begin
          dec.dest_reg  = rd;
          dec.reg_write = 1'b1;
          dec.op1       = rs_data;
          dec.op2       = rt_data;
          case (funct)
            6'h20: dec.alu_ctrl = ALU_ADD;
            6'h21: dec.alu_ctrl = ALU_ADDU;
            6'h22: dec.alu_ctrl = ALU_SUB;
            6'h23: dec.alu_ctrl = ALU_SUBU;
            6'h24: dec.alu_ctrl = ALU_AND;
            6'h25: dec.alu_ctrl = ALU_OR;
            6'h26: dec.alu_ctrl = ALU_XOR;
            6'h27: dec.alu_ctrl = ALU_NOR;
            6'h2A: dec.alu_ctrl = ALU_SLT;
            6'h00: begin dec.alu_ctrl = ALU_SLL; dec.op1 = shamt; end
            6'h02: begin dec.alu_ctrl = ALU_SRL; dec.op1 = shamt; end
            6'h03: begin dec.alu_ctrl = ALU_SRA; dec.op1 = shamt; end
            6'h04: dec.alu_ctrl = ALU_SLLV;
            6'h06: dec.alu_ctrl = ALU_SRLV;
            6'h07: dec.alu_ctrl = ALU_SRAV;
            default: legal = 1'b0;
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
          dec.dest_reg  = rt;
          dec.reg_write = 1'b1;
          dec.op1       = rs_data;
          case (opcode)
            6'h08:   begin dec.alu_ctrl = ALU_ADD;  dec.op2 = sext; end
            6'h09:   begin dec.alu_ctrl = ALU_ADDU; dec.op2 = sext; end
            6'h0A:   begin dec.alu_ctrl = ALU_SLT;  dec.op2 = sext; end
            6'h0C:   begin dec.alu_ctrl = ALU_AND;  dec.op2 = zext; end
            6'h0D:   begin dec.alu_ctrl = ALU_OR;   dec.op2 = zext; end
            default: begin dec.alu_ctrl = ALU_XOR;  dec.op2 = zext; end
          endcase
        end
        6'h0F: begin
          // lui is done in the ALU as imm << 16
          dec.dest_reg  = rt;
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = ALU_SLL;
          dec.op1       = 32'd16;
          dec.op2       = zext;
        end
        6'h23: begin
          dec.dest_reg  = rt;
          dec.reg_write = 1'b1;
          dec.mem_read  = 1'b1;
          dec.alu_ctrl  = ALU_ADDU;
          dec.op1       = rs_data;
          dec.op2       = sext;
        end
        6'h2B: begin
          dec.dest_reg   = rt;
          dec.mem_write  = 1'b1;
          dec.alu_ctrl   = ALU_ADDU;
          dec.op1        = rs_data;
          dec.op2        = sext;
          dec.store_data = rt_data;
        end
        6'h04, 6'h05: begin
          dec.dest_reg  = rt;
          dec.alu_ctrl  = ALU_SUB;
          dec.op1       = rs_data;
          dec.op2       = rt_data;
          dec.branch_eq = (opcode == 6'h04);
          dec.branch_ne = (opcode == 6'h05);
        end
        default: legal = 1'b0;
      endcase
      if (!legal) begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.illegal = 1'b1;
      end
      // $0 is hardwired, so writes to it are dropped here rather than in WB
      if (dec.dest_reg == 5'd0) dec.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) ex_q <= '0;
    else if (!stall)    ex_q <= dec;
  end

  assign valid      = ex_q.valid;
  assign illegal    = ex_q.illegal;
  assign alu_ctrl   = ex_q.alu_ctrl;
  assign op1        = ex_q.op1;
  assign op2        = ex_q.op2;
  assign store_data = ex_q.store_data;
  assign dest_reg   = ex_q.dest_reg;
  assign reg_write  = ex_q.reg_write;
  assign mem_read   = ex_q.mem_read;
  assign mem_write  = ex_q.mem_write;
  assign branch_eq  = ex_q.branch_eq;
  assign branch_ne  = ex_q.branch_ne;

endmodule
